// File: rtl/dpram_fifo_ctrl.sv
// Synchronous FIFO controller that owns both ports of a one-cycle-latency dual-port RAM.
// Define DPRAM_FIFO_ERR_EN to add sticky overflow/underflow flags.
module dpram_fifo_ctrl #(
    parameter  int DEPTH   = 64,
    parameter  int D_WIDTH = 8,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [D_WIDTH-1:0] wr_data,
    output logic               full,
    input  logic               rd_en,
    output logic [D_WIDTH-1:0] rd_data,
    output logic               rd_valid,
    output logic               empty,
`ifdef DPRAM_FIFO_ERR_EN
    output logic               overflow,
    output logic               underflow,
`endif
    output logic [AW:0]        count,
    output logic               we_a,
    output logic [AW-1:0]      addr_a,
    output logic [D_WIDTH-1:0] d_in_a,
    output logic               we_b,
    output logic [AW-1:0]      addr_b,
    input  logic [D_WIDTH-1:0] d_out_b
);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        push_ok;
    logic        pop_ok;

    // Handshake: a push is taken on any edge where wr_en=1 and full=0, a pop where
    // rd_en=1 and empty=0; requests made against the opposite flag are dropped, and
    // each accepted pop returns its word with rd_valid=1 exactly one cycle later.
    assign push_ok = wr_en & ~full;
    assign pop_ok  = rd_en & ~empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

    assign we_a    = push_ok;
    assign addr_a  = wr_ptr[AW-1:0];
    assign d_in_a  = wr_data;
    assign we_b    = 1'b0;
    assign addr_b  = rd_ptr[AW-1:0];
    assign rd_data = d_out_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_valid <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr + {{AW{1'b0}}, push_ok};
            rd_ptr   <= rd_ptr + {{AW{1'b0}}, pop_ok};
            rd_valid <= pop_ok;
        end
    end

`ifdef DPRAM_FIFO_ERR_EN
    // Sticky until reset so a dropped request is never missed by slow software polling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full)  overflow  <= 1'b1;
            if (rd_en && empty) underflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Self-checking bench for dpram_fifo_ctrl with a behavioural registered-read RAM model.
module tb_dpram_fifo_ctrl;

    localparam int DEPTH = 64;
    localparam int DW    = 8;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          full;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          empty;
    logic [AW:0]   count;
    logic          we_a;
    logic [AW-1:0] addr_a;
    logic [DW-1:0] d_in_a;
    logic          we_b;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] d_out_b;
`ifdef DPRAM_FIFO_ERR_EN
    logic          overflow;
    logic          underflow;
`endif

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] exp_q[$];
    int            model_count;
    int            checks;
    int            errors;

    always #5 clk = ~clk;

    dpram_fifo_ctrl #(.DEPTH(DEPTH), .D_WIDTH(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .empty    (empty),
`ifdef DPRAM_FIFO_ERR_EN
        .overflow (overflow),
        .underflow(underflow),
`endif
        .count    (count),
        .we_a     (we_a),
        .addr_a   (addr_a),
        .d_in_a   (d_in_a),
        .we_b     (we_b),
        .addr_b   (addr_b),
        .d_out_b  (d_out_b)
    );

    // RAM model: write on port A, registered read on port B.
    always @(posedge clk) begin
        if (we_a) mem[addr_a] <= d_in_a;
        d_out_b <= mem[addr_b];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_flags();
        check("count", 32'(count), 32'(model_count));
        check("empty", 32'(empty), 32'(model_count == 0));
        check("full", 32'(full), 32'(model_count == DEPTH));
        check("we_b", 32'(we_b), 32'd0);
    endtask

    // Called just after a negedge; drives one cycle and checks the result at the next negedge.
    task automatic step(input logic we, input logic [DW-1:0] wd, input logic re);
        logic push_m;
        logic pop_m;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        push_m  = we && (model_count != DEPTH);
        pop_m   = re && (model_count != 0);
        #1;
        check("we_a", 32'(we_a), 32'(push_m));
        if (push_m) check("d_in_a", 32'(d_in_a), 32'(wd));
        if (push_m) exp_q.push_back(wd);
        @(posedge clk);
        model_count = model_count + int'(push_m) - int'(pop_m);
        @(negedge clk);
        check("rd_valid", 32'(rd_valid), 32'(pop_m));
        if (pop_m) begin
            if (exp_q.size() == 0) check("rd_queue_empty", 32'd1, 32'd0);
            else check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
        end
        check_flags();
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        model_count = 0;
        rst_n       = 1'b0;
        wr_en       = 1'b0;
        wr_data     = '0;
        rd_en       = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset then idle
        check_flags();
        check("rd_valid_rst", 32'(rd_valid), 32'd0);
        check("we_a_rst", 32'(we_a), 32'd0);
`ifdef DPRAM_FIFO_ERR_EN
        check("overflow_rst", 32'(overflow), 32'd0);
        check("underflow_rst", 32'(underflow), 32'd0);
`endif

        // Two pushes, two back-to-back pops
        step(1'b1, 8'h33, 1'b0);
        step(1'b1, 8'h44, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        check("pop1_data", 32'(rd_data), 32'h33);
        step(1'b0, 8'h00, 1'b1);
        check("pop2_data", 32'(rd_data), 32'h44);
        step(1'b0, 8'h00, 1'b0);
        check("empty_after", 32'(empty), 32'd1);

        // Fill completely, push while full, drain
        for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(i), 1'b0);
        check("full_64", 32'(full), 32'd1);
        check("count_64", 32'(count), 32'd64);
        step(1'b1, 8'hFF, 1'b0);
`ifdef DPRAM_FIFO_ERR_EN
        check("overflow_set", 32'(overflow), 32'd1);
`endif
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1);
        check("empty_drained", 32'(empty), 32'd1);

        // Fill to 63, then sustained simultaneous push/pop across the pointer wrap
        for (int i = 0; i < DEPTH - 1; i++) step(1'b1, DW'(i + 8'h80), 1'b0);
        for (int i = 0; i < 70; i++) begin
            step(1'b1, 8'h55, 1'b1);
            check("count_63", 32'(count), 32'd63);
        end
        for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 8'h00, 1'b1);

        // Pop while empty with a simultaneous push
        step(1'b1, 8'h44, 1'b1);
        check("ue_rd_valid", 32'(rd_valid), 32'd0);
        check("ue_count", 32'(count), 32'd1);
`ifdef DPRAM_FIFO_ERR_EN
        check("underflow_set", 32'(underflow), 32'd1);
`endif
        step(1'b0, 8'h00, 1'b1);
        check("ue_data", 32'(rd_data), 32'h44);

        // Random traffic
        for (int i = 0; i < 300; i++)
            step(1'(($urandom_range(0, 99) < 55)), DW'($urandom_range(0, 255)),
                 1'(($urandom_range(0, 99) < 45)));
        while (model_count != 0) step(1'b0, 8'h00, 1'b1);

        // Asynchronous reset in the middle of a pop burst
        for (int i = 0; i < 5; i++) step(1'b1, DW'(i + 8'h10), 1'b0);
        step(1'b0, 8'h00, 1'b1);
        rd_en = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        model_count = 0;
        exp_q.delete();
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        @(negedge clk);
        rd_en = 1'b0;
        rst_n = 1'b1;
        #1;
`ifdef DPRAM_FIFO_ERR_EN
        check("overflow_clr", 32'(overflow), 32'd0);
        check("underflow_clr", 32'(underflow), 32'd0);
`endif
        step(1'b1, 8'h77, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        check("post_rst_data", 32'(rd_data), 32'h77);
        step(1'b0, 8'h00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
